// File: rtl/pipe_hazard_ctrl_if.sv
// Decode/memory-stage hazard control bundle between the LC-3b datapath (master)
// and the hazard/stall controller (slave).
interface pipe_hazard_ctrl_if #(
  parameter int REGS  = 8,
  parameter int CNT_W = 16
);
  localparam int RW = $clog2(REGS);

  logic          id_valid;
  logic [RW-1:0] id_sr1;
  logic [RW-1:0] id_sr2;
  logic          id_sr1_use;
  logic          id_sr2_use;
  logic [RW-1:0] id_dest;
  logic          id_dest_we;
  logic          id_is_load;
  logic          mem_req;
  logic          mem_indirect;
  logic          mem_resp;
  logic          br_taken;

  logic             stall_id;
  logic             stall_pipe;
  logic             flush;
  logic             indirect_sel;
  logic [REGS-1:0]  busy_mask;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] memwait_cnt;

  modport master (
    output id_valid, id_sr1, id_sr2, id_sr1_use, id_sr2_use, id_dest,
           id_dest_we, id_is_load, mem_req, mem_indirect, mem_resp, br_taken,
    input  stall_id, stall_pipe, flush, indirect_sel, busy_mask, stall_cnt,
           memwait_cnt
  );

  modport slave (
    input  id_valid, id_sr1, id_sr2, id_sr1_use, id_sr2_use, id_dest,
           id_dest_we, id_is_load, mem_req, mem_indirect, mem_resp, br_taken,
    output stall_id, stall_pipe, flush, indirect_sel, busy_mask, stall_cnt,
           memwait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: in-flight destination scoreboard for RAW stalls,
// memory-stage access FSM (single and LDI/STI indirect), branch flush, stall counters.
module pipe_hazard_ctrl #(
  parameter int DEPTH  = 3,
  parameter int REGS   = 8,
  parameter int FWD_EN = 0,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int RW = $clog2(REGS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {ACC1 = 1'b0, ACC2 = 1'b1} mem_state_e;

  mem_state_e state_q, state_d;

  logic [DEPTH-1:0] sb_v_q, sb_v_d;
  logic [DEPTH-1:0] sb_load_q, sb_load_d;
  logic [RW-1:0]    sb_dest_q [DEPTH];
  logic [RW-1:0]    sb_dest_d [DEPTH];

  logic [REGS-1:0]  busy_mask_q, busy_mask_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;

  logic [DEPTH-1:0] match;
  logic             raw;
  logic             stall_id;
  logic             stall_pipe;
  logic             flush;
  logic             indirect_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != '1)) ? v + CNT_ONE : v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC1;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC1:    if (hz.mem_req && hz.mem_resp && hz.mem_indirect) state_d = ACC2;
      ACC2:    if (hz.mem_resp) state_d = ACC1;
      default: state_d = ACC1;
    endcase
  end

  // While rst is high the FSM is treated as already back in ACC1.
  always_comb begin
    stall_pipe   = 1'b0;
    indirect_sel = 1'b0;
    if (rst || state_q == ACC1) begin
      stall_pipe = hz.mem_req && (!hz.mem_resp || hz.mem_indirect);
    end else begin
      indirect_sel = 1'b1;
      stall_pipe   = !hz.mem_resp;
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = sb_v_q[i] &&
                 ((hz.id_sr1_use && (hz.id_sr1 == sb_dest_q[i])) ||
                  (hz.id_sr2_use && (hz.id_sr2 == sb_dest_q[i])));
    end
  end

  // With forwarding only a load still in EX cannot be bypassed in time.
  assign raw      = (FWD_EN != 0) ? (match[0] && sb_load_q[0]) : (|match);
  assign flush    = !rst && hz.br_taken && !stall_pipe;
  assign stall_id = !rst && hz.id_valid && raw && !flush && !stall_pipe;

  always_comb begin
    sb_v_d    = sb_v_q;
    sb_load_d = sb_load_q;
    sb_dest_d = sb_dest_q;
    if (!stall_pipe) begin
      for (int i = 2; i < DEPTH; i++) begin
        sb_v_d[i]    = sb_v_q[i-1];
        sb_load_d[i] = sb_load_q[i-1];
        sb_dest_d[i] = sb_dest_q[i-1];
      end
      sb_v_d[1]    = sb_v_q[0] && !flush;
      sb_load_d[1] = sb_load_q[0];
      sb_dest_d[1] = sb_dest_q[0];
      sb_v_d[0]    = hz.id_valid && hz.id_dest_we && !stall_id && !flush;
      sb_load_d[0] = hz.id_is_load;
      sb_dest_d[0] = hz.id_dest;
    end
  end

  always_comb begin
    busy_mask_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sb_v_d[i]) busy_mask_d[sb_dest_d[i]] = 1'b1;
    end
    stall_cnt_d   = sat_inc(stall_cnt_q, stall_id);
    memwait_cnt_d = sat_inc(memwait_cnt_q, stall_pipe);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v_q        <= '0;
      busy_mask_q   <= '0;
      stall_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      sb_v_q        <= sb_v_d;
      busy_mask_q   <= busy_mask_d;
      stall_cnt_q   <= stall_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
    end
  end

  // Entry payload only matters under its valid bit, so it carries no reset.
  always_ff @(posedge clk) begin
    sb_load_q <= sb_load_d;
    sb_dest_q <= sb_dest_d;
  end

  assign hz.stall_id     = stall_id;
  assign hz.stall_pipe   = stall_pipe;
  assign hz.flush        = flush;
  assign hz.indirect_sel = indirect_sel;
  assign hz.busy_mask    = busy_mask_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.memwait_cnt  = memwait_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: three instances (no forwarding, forwarding, 4-bit counters)
// share one stimulus stream and are compared against a queue-based pending-write model.
module tb_pipe_hazard_ctrl;
  localparam int DEPTH = 3;
  localparam int REGS  = 8;
  localparam int RW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          id_valid, id_sr1_use, id_sr2_use, id_dest_we, id_is_load;
  logic [RW-1:0] id_sr1, id_sr2, id_dest;
  logic          mem_req, mem_indirect, mem_resp, br_taken;

  pipe_hazard_ctrl_if #(.REGS(REGS), .CNT_W(16)) if0 ();
  pipe_hazard_ctrl_if #(.REGS(REGS), .CNT_W(16)) if1 ();
  pipe_hazard_ctrl_if #(.REGS(REGS), .CNT_W(4))  if2 ();

  assign if0.id_valid = id_valid;     assign if1.id_valid = id_valid;     assign if2.id_valid = id_valid;
  assign if0.id_sr1 = id_sr1;         assign if1.id_sr1 = id_sr1;         assign if2.id_sr1 = id_sr1;
  assign if0.id_sr2 = id_sr2;         assign if1.id_sr2 = id_sr2;         assign if2.id_sr2 = id_sr2;
  assign if0.id_sr1_use = id_sr1_use; assign if1.id_sr1_use = id_sr1_use; assign if2.id_sr1_use = id_sr1_use;
  assign if0.id_sr2_use = id_sr2_use; assign if1.id_sr2_use = id_sr2_use; assign if2.id_sr2_use = id_sr2_use;
  assign if0.id_dest = id_dest;       assign if1.id_dest = id_dest;       assign if2.id_dest = id_dest;
  assign if0.id_dest_we = id_dest_we; assign if1.id_dest_we = id_dest_we; assign if2.id_dest_we = id_dest_we;
  assign if0.id_is_load = id_is_load; assign if1.id_is_load = id_is_load; assign if2.id_is_load = id_is_load;
  assign if0.mem_req = mem_req;       assign if1.mem_req = mem_req;       assign if2.mem_req = mem_req;
  assign if0.mem_indirect = mem_indirect; assign if1.mem_indirect = mem_indirect; assign if2.mem_indirect = mem_indirect;
  assign if0.mem_resp = mem_resp;     assign if1.mem_resp = mem_resp;     assign if2.mem_resp = mem_resp;
  assign if0.br_taken = br_taken;     assign if1.br_taken = br_taken;     assign if2.br_taken = br_taken;

  pipe_hazard_ctrl #(.DEPTH(DEPTH), .REGS(REGS), .FWD_EN(0), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .hz(if0));
  pipe_hazard_ctrl #(.DEPTH(DEPTH), .REGS(REGS), .FWD_EN(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .hz(if1));
  pipe_hazard_ctrl #(.DEPTH(DEPTH), .REGS(REGS), .FWD_EN(0), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .hz(if2));

  int passed = 0;
  int total  = 0;

  // Reference model: every in-flight write is a record with its age in stages past decode.
  typedef struct {
    int fwd;
    int dest;
    bit load;
    int age;
  } pend_t;

  pend_t pq[$];
  bit    m_second;
  int    m_scnt[2];
  int    m_mcnt;

  function automatic bit m_stall_pipe();
    if (!rst && m_second) return !mem_resp;
    return mem_req && (!mem_resp || mem_indirect);
  endfunction

  function automatic bit m_flush();
    return !rst && br_taken && !m_stall_pipe();
  endfunction

  function automatic bit m_raw(int fwd);
    bit hit;
    foreach (pq[k]) begin
      if (pq[k].fwd == fwd) begin
        hit = (id_sr1_use && (int'(id_sr1) == pq[k].dest)) ||
              (id_sr2_use && (int'(id_sr2) == pq[k].dest));
        if (hit && (fwd == 0 || (pq[k].age == 0 && pq[k].load))) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit m_stall_id(int fwd);
    return !rst && id_valid && m_raw(fwd) && !m_flush() && !m_stall_pipe();
  endfunction

  function automatic logic [REGS-1:0] m_busy(int fwd);
    logic [REGS-1:0] b;
    b = '0;
    foreach (pq[k]) if (pq[k].fwd == fwd) b[pq[k].dest] = 1'b1;
    return b;
  endfunction

  function automatic int sat(int v, int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    bit    sp, fl;
    bit    si[2];
    pend_t nq[$];
    pend_t e;
    if (rst) begin
      pq.delete();
      m_second = 1'b0;
      m_scnt   = '{0, 0};
      m_mcnt   = 0;
      return;
    end
    sp = m_stall_pipe();
    fl = m_flush();
    si[0] = m_stall_id(0);
    si[1] = m_stall_id(1);
    for (int f = 0; f < 2; f++) if (si[f]) m_scnt[f]++;
    if (sp) m_mcnt++;
    if (m_second) m_second = !mem_resp;
    else          m_second = mem_req && mem_resp && mem_indirect;
    if (!sp) begin
      foreach (pq[k]) begin
        e = pq[k];
        if (!(fl && e.age == 0)) begin
          e.age++;
          if (e.age < DEPTH) nq.push_back(e);
        end
      end
      for (int f = 0; f < 2; f++) begin
        if (id_valid && id_dest_we && !si[f] && !fl) begin
          e.fwd = f; e.dest = int'(id_dest); e.load = id_is_load; e.age = 0;
          nq.push_back(e);
        end
      end
      pq = nq;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_sr1_use = 0; id_sr2_use = 0;
    id_dest = 0; id_dest_we = 0; id_is_load = 0;
    mem_req = 0; mem_indirect = 0; mem_resp = 0; br_taken = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    @(negedge clk);
    total++; if ({if0.stall_id, if0.stall_pipe, if0.flush, if0.indirect_sel} !== 4'b0)
      $display("FAIL reset_ctl got=%b exp=0000", {if0.stall_id, if0.stall_pipe, if0.flush, if0.indirect_sel}); else passed++;
    total++; if (if0.busy_mask !== 8'h00) $display("FAIL reset_busy got=%h exp=00", if0.busy_mask); else passed++;
    total++; if ({if0.stall_cnt, if0.memwait_cnt} !== 32'h0)
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", if0.stall_cnt, if0.memwait_cnt); else passed++;
    br_taken = 1'b1;
    #1;
    total++; if (if0.flush !== 1'b0) $display("FAIL reset_flush_masked got=%b exp=0", if0.flush); else passed++;
    mem_req = 1'b1;
    #1;
    total++; if ({if0.stall_pipe, if0.flush} !== 2'b10)
      $display("FAIL reset_stall_pipe_follows_req got=%b exp=10", {if0.stall_pipe, if0.flush}); else passed++;
    tick();
    idle();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if ({if0.stall_id, if0.stall_pipe, if0.flush, if0.indirect_sel, if0.busy_mask} !== 12'h0)
        $display("FAIL idle_outputs cyc=%0d got=%h exp=0", c, {if0.stall_id, if0.stall_pipe, if0.flush, if0.indirect_sel, if0.busy_mask}); else passed++;
      tick();
    end
    @(negedge clk);
    total++; if ({if0.stall_cnt, if0.memwait_cnt} !== 32'h0)
      $display("FAIL idle_cnt got=%0d/%0d exp=0/0", if0.stall_cnt, if0.memwait_cnt); else passed++;
  endtask

  task automatic test_raw_stall();
    int  n0, n1;
    bit  done;
    do_reset();
    id_valid = 1; id_sr1 = 5; id_sr2 = 6; id_sr1_use = 1; id_sr2_use = 1;
    id_dest = 1; id_dest_we = 1; id_is_load = 0;
    @(negedge clk);
    total++; if (if0.stall_id !== 1'b0) $display("FAIL raw_producer_stall got=%b exp=0", if0.stall_id); else passed++;
    tick();
    id_sr1 = 1; id_sr2 = 1; id_dest = 2;
    n0 = 0; n1 = 0; done = 0;
    for (int c = 0; c < 8 && !done; c++) begin
      @(negedge clk);
      if (if0.stall_id) begin
        n0++;
        total++; if (if0.busy_mask[1] !== 1'b1)
          $display("FAIL raw_busy_bit1 cyc=%0d got=%h exp=bit1 set", c, if0.busy_mask); else passed++;
      end
      if (c == 0 && if1.stall_id) n1++;
      done = !if0.stall_id;
      tick();
    end
    idle();
    total++; if (n0 !== 3) $display("FAIL raw_bubbles_nofwd got=%0d exp=3", n0); else passed++;
    total++; if (n1 !== 0) $display("FAIL raw_bubbles_fwd_alu got=%0d exp=0", n1); else passed++;
    @(negedge clk);
    total++; if (if0.stall_cnt !== 16'd3) $display("FAIL raw_stall_cnt got=%0d exp=3", if0.stall_cnt); else passed++;
    total++; if (if1.stall_cnt !== 16'd0) $display("FAIL raw_stall_cnt_fwd got=%0d exp=0", if1.stall_cnt); else passed++;
  endtask

  task automatic test_load_use();
    int n0, n1;
    bit d0, d1;
    do_reset();
    id_valid = 1; id_sr1_use = 0; id_sr2_use = 0; id_dest = 3; id_dest_we = 1; id_is_load = 1;
    @(negedge clk);
    tick();
    id_sr1 = 3; id_sr1_use = 1; id_sr2_use = 0; id_dest = 4; id_is_load = 0;
    n0 = 0; n1 = 0; d0 = 0; d1 = 0;
    for (int c = 0; c < 8 && !(d0 && d1); c++) begin
      @(negedge clk);
      if (!d0) begin if (if0.stall_id) n0++; else d0 = 1; end
      if (!d1) begin if (if1.stall_id) n1++; else d1 = 1; end
      tick();
    end
    idle();
    total++; if (n1 !== 1) $display("FAIL load_use_bubbles_fwd got=%0d exp=1", n1); else passed++;
    total++; if (n0 !== 3) $display("FAIL load_use_bubbles_nofwd got=%0d exp=3", n0); else passed++;
  endtask

  task automatic test_indirect();
    bit rsp[7] = '{0, 0, 1, 0, 0, 0, 1};
    bit esp[7] = '{1, 1, 1, 1, 1, 1, 0};
    bit eis[7] = '{0, 0, 0, 1, 1, 1, 1};
    do_reset();
    mem_req = 1; mem_indirect = 1;
    for (int i = 0; i < 7; i++) begin
      mem_resp = rsp[i];
      @(negedge clk);
      total++; if ({if0.stall_pipe, if0.indirect_sel} !== {esp[i], eis[i]})
        $display("FAIL ldi_seq cyc=%0d got=%b%b exp=%b%b", i, if0.stall_pipe, if0.indirect_sel, esp[i], eis[i]); else passed++;
      tick();
    end
    idle();
    @(negedge clk);
    total++; if (if0.memwait_cnt !== 16'd6) $display("FAIL ldi_memwait got=%0d exp=6", if0.memwait_cnt); else passed++;
    total++; if (if2.memwait_cnt !== 4'd6) $display("FAIL ldi_memwait_w4 got=%0d exp=6", if2.memwait_cnt); else passed++;
    total++; if ({if0.stall_pipe, if0.indirect_sel} !== 2'b00)
      $display("FAIL ldi_after got=%b exp=00", {if0.stall_pipe, if0.indirect_sel}); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    id_valid = 1; id_dest = 2; id_dest_we = 1;
    @(negedge clk);
    tick();
    id_sr1 = 2; id_sr1_use = 1; id_dest = 5; br_taken = 1;
    @(negedge clk);
    total++; if ({if0.flush, if0.stall_id} !== 2'b10)
      $display("FAIL flush_prio got=%b exp=10", {if0.flush, if0.stall_id}); else passed++;
    total++; if (if0.busy_mask !== 8'h04) $display("FAIL flush_busy_before got=%h exp=04", if0.busy_mask); else passed++;
    tick();
    idle();
    @(negedge clk);
    total++; if (if0.busy_mask !== 8'h00) $display("FAIL flush_busy_after got=%h exp=00", if0.busy_mask); else passed++;
    total++; if (if1.busy_mask !== 8'h00) $display("FAIL flush_busy_after_fwd got=%h exp=00", if1.busy_mask); else passed++;
  endtask

  task automatic test_reset_in_acc2();
    do_reset();
    id_valid = 1; id_dest = 4; id_dest_we = 1;
    @(negedge clk);
    tick();
    idle();
    mem_req = 1; mem_indirect = 1; mem_resp = 1;
    @(negedge clk);
    total++; if ({if0.stall_pipe, if0.indirect_sel} !== 2'b10)
      $display("FAIL acc2_entry got=%b exp=10", {if0.stall_pipe, if0.indirect_sel}); else passed++;
    tick();
    mem_resp = 0;
    @(negedge clk);
    total++; if ({if0.stall_pipe, if0.indirect_sel} !== 2'b11)
      $display("FAIL acc2_state got=%b exp=11", {if0.stall_pipe, if0.indirect_sel}); else passed++;
    total++; if (if0.busy_mask !== 8'h10) $display("FAIL acc2_busy_frozen got=%h exp=10", if0.busy_mask); else passed++;
    rst = 1;
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    total++; if ({if0.stall_pipe, if0.indirect_sel} !== 2'b00)
      $display("FAIL acc2_rst_fsm got=%b exp=00", {if0.stall_pipe, if0.indirect_sel}); else passed++;
    total++; if (if0.busy_mask !== 8'h00) $display("FAIL acc2_rst_busy got=%h exp=00", if0.busy_mask); else passed++;
    total++; if (if0.memwait_cnt !== 16'd0) $display("FAIL acc2_rst_cnt got=%0d exp=0", if0.memwait_cnt); else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    id_valid = 1; id_sr1 = 1; id_sr2 = 1; id_sr1_use = 1; id_sr2_use = 1;
    id_dest = 1; id_dest_we = 1;
    for (int c = 0; c < 28; c++) tick();
    idle();
    @(negedge clk);
    total++; if (if2.stall_cnt !== 4'd15) $display("FAIL sat_stall_cnt_w4 got=%0d exp=15", if2.stall_cnt); else passed++;
    total++; if (if0.stall_cnt !== 16'd21) $display("FAIL sat_stall_cnt_w16 got=%0d exp=21", if0.stall_cnt); else passed++;
    total++; if (if1.stall_cnt !== 16'd0) $display("FAIL sat_stall_cnt_fwd got=%0d exp=0", if1.stall_cnt); else passed++;
    mem_req = 1;
    for (int c = 0; c < 20; c++) tick();
    idle();
    @(negedge clk);
    total++; if (if2.memwait_cnt !== 4'd15) $display("FAIL sat_memwait_w4 got=%0d exp=15", if2.memwait_cnt); else passed++;
    total++; if (if0.memwait_cnt !== 16'd20) $display("FAIL sat_memwait_w16 got=%0d exp=20", if0.memwait_cnt); else passed++;
  endtask

  task automatic test_random();
    logic [2:0] exp_ctl;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_sr1       = RW'($urandom_range(0, 3));
      id_sr2       = RW'($urandom_range(0, 3));
      id_sr1_use   = $urandom_range(0, 1);
      id_sr2_use   = $urandom_range(0, 1);
      id_dest      = RW'($urandom_range(0, 3));
      id_dest_we   = ($urandom_range(0, 3) != 0);
      id_is_load   = $urandom_range(0, 1);
      mem_req      = ($urandom_range(0, 2) == 0);
      mem_indirect = ($urandom_range(0, 2) == 0);
      mem_resp     = $urandom_range(0, 1);
      br_taken     = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      exp_ctl = {m_stall_pipe(), m_flush(), !rst && m_second};
      total++; if ({if0.stall_pipe, if0.flush, if0.indirect_sel} !== exp_ctl)
        $display("FAIL rnd_ctl0 cyc=%0d got=%b exp=%b", c, {if0.stall_pipe, if0.flush, if0.indirect_sel}, exp_ctl); else passed++;
      total++; if ({if1.stall_pipe, if1.flush, if1.indirect_sel} !== exp_ctl)
        $display("FAIL rnd_ctl1 cyc=%0d got=%b exp=%b", c, {if1.stall_pipe, if1.flush, if1.indirect_sel}, exp_ctl); else passed++;
      total++; if ({if0.stall_id, if1.stall_id, if2.stall_id} !== {m_stall_id(0), m_stall_id(1), m_stall_id(0)})
        $display("FAIL rnd_stall_id cyc=%0d got=%b exp=%b", c, {if0.stall_id, if1.stall_id, if2.stall_id},
                 {m_stall_id(0), m_stall_id(1), m_stall_id(0)}); else passed++;
      total++; if (if0.busy_mask !== m_busy(0)) $display("FAIL rnd_busy0 cyc=%0d got=%h exp=%h", c, if0.busy_mask, m_busy(0)); else passed++;
      total++; if (if1.busy_mask !== m_busy(1)) $display("FAIL rnd_busy1 cyc=%0d got=%h exp=%h", c, if1.busy_mask, m_busy(1)); else passed++;
      total++; if ({int'(if0.stall_cnt), int'(if1.stall_cnt), int'(if2.stall_cnt)} !==
                   {sat(m_scnt[0], 16), sat(m_scnt[1], 16), sat(m_scnt[0], 4)})
        $display("FAIL rnd_stall_cnt cyc=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c, if0.stall_cnt, if1.stall_cnt, if2.stall_cnt,
                 sat(m_scnt[0], 16), sat(m_scnt[1], 16), sat(m_scnt[0], 4)); else passed++;
      total++; if ({int'(if0.memwait_cnt), int'(if2.memwait_cnt)} !== {sat(m_mcnt, 16), sat(m_mcnt, 4)})
        $display("FAIL rnd_memwait cyc=%0d got=%0d/%0d exp=%0d/%0d", c, if0.memwait_cnt, if2.memwait_cnt,
                 sat(m_mcnt, 16), sat(m_mcnt, 4)); else passed++;
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_raw_stall();
    test_load_use();
    test_indirect();
    test_flush();
    test_reset_in_acc2();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and stall controller for the pipelined LC-3b datapath. It sits beside the decode-stage control-word generator. A scoreboard of in-flight destination registers produces decode stalls and bubbles. A memory-stage FSM sequences single and indirect (LDI/STI) data accesses with a pipeline freeze. It also generates branch flushes and keeps saturating stall counters.

## Interface
- DEPTH, 3: pipeline stages after decode that can hold a pending write. Index 0 = EX, 1 = MEM, DEPTH-1 = WB. Legal range ≥ 2.
- REGS, 8: architectural registers. RW = $clog2(REGS).
- FWD_EN, 0: 0 = stall on any RAW match. 1 = datapath forwards, so stall only on a load-use match against EX.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock. One clock domain; everything is synchronous to its rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  decode holds a valid instruction.
- id_sr1, id_sr2  in  RW  source register indices.
- id_sr1_use, id_sr2_use  in  1  source is actually read.
- id_dest  in  RW  destination index.
- id_dest_we  in  1  instruction writes the regfile.
- id_is_load  in  1  result comes from data memory (LDR/LDB/LDI).
- mem_req  in  1  MEM-stage instruction accesses data memory (d_mem_read | d_mem_write).
- mem_indirect  in  1  MEM-stage instruction is LDI/STI and needs two accesses.
- mem_resp  in  1  data memory completes the current access this cycle.
- br_taken  in  1  branch resolved taken in MEM.
- stall_id  out  1  hold PC/IR/decode and inject a bubble into EX.
- stall_pipe  out  1  freeze every pipeline register.
- flush  out  1  squash IF/ID and EX contents.
- indirect_sel  out  1  MEM address mux. 0 = MAR, 1 = MDR (second access).
- busy_mask  out  REGS  bit r set when register r has a pending write in any scoreboard entry.
- stall_cnt  out  CNT_W  cycles with stall_id = 1.
- memwait_cnt  out  CNT_W  cycles with stall_pipe = 1.

## Operation
Scoreboard: entries sb[0..DEPTH-1], each holding {v, dest, load}.
- Advances only when stall_pipe = 0.
- sb[i] <= sb[i-1] for i ≥ 2.
- sb[1] <= flush ? 0 : sb[0].
- sb[0] <= {1, id_dest, id_is_load} if id_valid & id_dest_we & !stall_id & !flush; otherwise 0.
- When stall_pipe = 1, all entries hold.

Hazard:
- match(i) = sb[i].v & ((id_sr1_use & id_sr1 == sb[i].dest) | (id_sr2_use & id_sr2 == sb[i].dest)).
- FWD_EN=0: raw = OR of match(i) over all i.
- FWD_EN=1: raw = match(0) & sb[0].load.
- stall_id = id_valid & raw & !flush & !stall_pipe.
- busy_mask = OR over valid entries of the one-hot of dest.

Flush:
- flush = br_taken & !stall_pipe.
- Flush has priority over stall_id.

Memory FSM, states ACC1 and ACC2:
- ACC1: indirect_sel = 0.
  - If mem_req & !mem_resp: stall_pipe = 1, stay in ACC1.
  - If mem_req & mem_resp & mem_indirect: stall_pipe = 1, go to ACC2.
  - If mem_req & mem_resp & !mem_indirect: stall_pipe = 0.
  - If !mem_req: stall_pipe = 0.
- ACC2: indirect_sel = 1, stall_pipe = !mem_resp.
  - On mem_resp, go to ACC1.
  - mem_req is ignored in ACC2; the instruction is frozen in MEM.

Counters:
- Increment by 1 per qualifying cycle.
- Saturate at all-ones and never wrap.

## Timing
- Reset values: all sb.v = 0, FSM = ACC1, both counters = 0, busy_mask = 0.
- Outputs during reset: stall_id = 0 and flush = 0. stall_pipe follows mem_req combinationally from ACC1.
- stall_id, stall_pipe, flush and indirect_sel are combinational from inputs plus state, valid in the same cycle.
- busy_mask and the counters are registered; they reflect the previous edge.
- Single access: freeze lasts exactly the wait cycles until mem_resp. The cycle carrying mem_resp is unfrozen.
- Indirect access: the first mem_resp cycle is still frozen. The second access starts on the next cycle with indirect_sel = 1. The minimum total freeze for an indirect access is 1 cycle (two zero-wait responses).
- A RAW stall repeats each cycle until the producing entry leaves the scoreboard.
  - FWD_EN=0, DEPTH=3, dependent immediately after producer: 3 bubbles.
  - FWD_EN=1, load-use: 1 bubble.
- br_taken during stall_pipe is ignored; the source must hold it until unfrozen.
- rst asserted mid-access: FSM returns to ACC1, the scoreboard clears and counters clear on that edge, regardless of mem_resp.

## Test plan
- Reset with mem_req = 0 → all outputs 0, busy_mask = 0; counters stay 0 over 10 idle cycles.
- FWD_EN=0, DEPTH=3: ADD R1 then ADD R2,R1,R1 back-to-back, zero memory wait → stall_id high exactly 3 cycles, stall_cnt = 3, busy_mask bit 1 set during those cycles.
- FWD_EN=1: LDR R3 then ADD R4,R3,#1 → exactly 1 bubble. The same sequence with ADD R3 as producer → 0 bubbles.
- LDI with mem_resp after 2 and then 3 wait cycles → stall_pipe high for 2+1+3 = 6 cycles, indirect_sel high only in the last 4, memwait_cnt = 6.
- br_taken with a dependent instruction in decode → flush = 1, stall_id = 0. The next cycle sb[1] is invalid and busy_mask drops the squashed dest.
- rst pulsed in ACC2 → next cycle indirect_sel = 0, busy_mask = 0. Separately, force CNT_W = 4 and stall 20 cycles → stall_cnt holds at 15.
